// File: rtl/spi_reg_ctrl_if.sv
// Bundle of SPI slave byte-path, register-bus and error-reporting signals
// for spi_reg_ctrl. The master modport is the controller's view and the
// slave modport is the view of the surrounding SPI slave / register fabric.
//
// Handshakes:
//   - slv_rx_valid/slv_rx_read: a byte is offered while slv_rx_valid is high.
//     It is consumed by a one-cycle slv_rx_read pulse in the cycle after the
//     controller sees it. The offering side drops slv_rx_valid once it has
//     seen that pulse.
//   - slv_tx_valid/slv_tx_ready: slv_tx_valid is a one-cycle load strobe. It
//     is only raised in a cycle where slv_tx_ready was high.
//   - reg_we/reg_re with reg_ack: a request is held stable until the cycle
//     in which reg_ack is sampled high, or until it is abandoned on timeout.
//     reg_rdata is only meaningful while reg_ack is high.
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic [7:0]        slv_rx_data;
    logic              slv_rx_valid;
    logic              slv_rx_read;
    logic [7:0]        slv_tx_data;
    logic              slv_tx_valid;
    logic              slv_tx_ready;
    logic              slv_error;
    logic              cs_n;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              reg_ack;
    logic              frame_active;
    logic              err_sticky;
    logic              err_clr;
    logic [7:0]        err_count;
    logic [2:0]        dbg_state;

    modport master (
        input  slv_rx_data, slv_rx_valid, slv_tx_ready, slv_error, cs_n,
               reg_rdata, reg_ack, err_clr,
        output slv_rx_read, slv_tx_data, slv_tx_valid, reg_addr, reg_wdata,
               reg_we, reg_re, frame_active, err_sticky, err_count, dbg_state
    );

    modport slave (
        output slv_rx_data, slv_rx_valid, slv_tx_ready, slv_error, cs_n,
               reg_rdata, reg_ack, err_clr,
        input  slv_rx_read, slv_tx_data, slv_tx_valid, reg_addr, reg_wdata,
               reg_we, reg_re, frame_active, err_sticky, err_count, dbg_state
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI-to-register-bus command sequencer. Each chip-select frame becomes one
// register burst: a command byte (bit7 = read, low bits = start address),
// then write data bytes or read dummies, with the address auto-incrementing.
// Read data is prefetched so the next transmit byte is loaded before the
// dummy byte that clocks it out arrives.
module spi_reg_ctrl #(
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    spi_reg_ctrl_if.master bus
);

    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR_BYTE,
        S_WR_WAIT,
        S_RD_REQ,
        S_RD_LOAD,
        S_RD_DUMMY
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic              r_we;
    logic              r_re;
    logic              r_rx_read;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic [7:0]        r_rdata;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_active;
    logic              r_abort;
    logic              r_err_sticky;
    logic [7:0]        r_err_count;
    logic              r_cs_meta;
    logic              r_cs_sync;
    logic              r_cs_prev;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        w_wdata_nxt;
    logic              w_we_nxt;
    logic              w_re_nxt;
    logic              w_rx_read_nxt;
    logic [7:0]        w_tx_data_nxt;
    logic              w_tx_valid_nxt;
    logic [7:0]        w_rdata_nxt;
    logic [TO_W-1:0]   w_to_cnt_nxt;
    logic              w_active_nxt;
    logic              w_abort_nxt;
    logic              w_trunc;

    logic              w_frame_start;
    logic              w_frame_end;
    logic              w_rx_take;
    logic              w_slv_err;
    logic              w_stop;
    logic              w_req;
    logic              w_acked;
    logic              w_timeout;
    logic              w_err;

    // Chip-select edges come from the second sync stage compared with its
    // delayed copy; idle-high reset values keep reset release edge-free.
    assign w_frame_start = r_cs_prev & ~r_cs_sync;
    assign w_frame_end   = ~r_cs_prev & r_cs_sync;
    // A byte still flagged valid during our own read pulse is the same byte.
    assign w_rx_take     = bus.slv_rx_valid & ~r_rx_read;
    assign w_slv_err     = bus.slv_error & r_active;
    assign w_stop        = w_frame_end | w_slv_err;
    assign w_req         = r_we | r_re;
    assign w_acked       = w_req & bus.reg_ack;
    assign w_timeout     = w_req & ~bus.reg_ack &
                           (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign w_err         = w_slv_err | w_timeout | w_trunc;

    // Double-synchronize cs_n and keep one extra stage for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_meta <= 1'b1;
            r_cs_sync <= 1'b1;
            r_cs_prev <= 1'b1;
        end else begin
            r_cs_meta <= bus.cs_n;
            r_cs_sync <= r_cs_meta;
            r_cs_prev <= r_cs_sync;
        end
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_rx_read  <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_rdata    <= '0;
            r_to_cnt   <= '0;
            r_active   <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_we       <= w_we_nxt;
            r_re       <= w_re_nxt;
            r_rx_read  <= w_rx_read_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_rdata    <= w_rdata_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_active   <= w_active_nxt;
            r_abort    <= w_abort_nxt;
        end
    end

    // Next-state and output decode. A frame end or slave error while a bus
    // request is outstanding only marks the frame aborted; the request is
    // finished (ack or timeout) before returning to IDLE.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_we_nxt       = r_we;
        w_re_nxt       = r_re;
        w_rx_read_nxt  = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = 1'b0;
        w_rdata_nxt    = r_rdata;
        w_to_cnt_nxt   = r_to_cnt;
        w_active_nxt   = r_active;
        w_abort_nxt    = r_abort;
        w_trunc        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_rx_take) begin
                    w_rx_read_nxt = 1'b1;
                end
                if (w_frame_start) begin
                    w_state_nxt  = S_CMD;
                    w_active_nxt = 1'b1;
                    w_abort_nxt  = 1'b0;
                end
            end

            S_CMD: begin
                if (w_stop) begin
                    if (w_rx_take) begin
                        w_rx_read_nxt = 1'b1;
                        w_trunc       = w_frame_end;
                    end
                    w_state_nxt  = S_IDLE;
                    w_active_nxt = 1'b0;
                end else if (w_rx_take) begin
                    w_rx_read_nxt = 1'b1;
                    w_addr_nxt    = bus.slv_rx_data[ADDR_W-1:0];
                    if (bus.slv_rx_data[7]) begin
                        w_state_nxt  = S_RD_REQ;
                        w_re_nxt     = 1'b1;
                        w_to_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = S_WR_BYTE;
                    end
                end
            end

            S_WR_BYTE: begin
                if (w_stop) begin
                    w_rx_read_nxt = w_rx_take;
                    w_state_nxt   = S_IDLE;
                    w_active_nxt  = 1'b0;
                end else if (w_rx_take) begin
                    w_rx_read_nxt = 1'b1;
                    w_wdata_nxt   = bus.slv_rx_data;
                    w_we_nxt      = 1'b1;
                    w_to_cnt_nxt  = '0;
                    w_state_nxt   = S_WR_WAIT;
                end
            end

            S_WR_WAIT: begin
                if (w_stop) begin
                    w_abort_nxt = 1'b1;
                end
                if (w_acked || w_timeout) begin
                    w_we_nxt   = 1'b0;
                    w_addr_nxt = r_addr + ADDR_W'(1);
                    if (r_abort || w_stop) begin
                        w_state_nxt  = S_IDLE;
                        w_active_nxt = 1'b0;
                        w_abort_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_WR_BYTE;
                    end
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end

            S_RD_REQ: begin
                if (w_stop) begin
                    w_abort_nxt = 1'b1;
                end
                if (w_acked || w_timeout) begin
                    w_re_nxt    = 1'b0;
                    w_rdata_nxt = w_acked ? bus.reg_rdata : 8'hFF;
                    if (r_abort || w_stop) begin
                        w_state_nxt  = S_IDLE;
                        w_active_nxt = 1'b0;
                        w_abort_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_RD_LOAD;
                    end
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end

            S_RD_LOAD: begin
                if (w_stop) begin
                    w_state_nxt  = S_IDLE;
                    w_active_nxt = 1'b0;
                end else if (bus.slv_tx_ready) begin
                    w_tx_data_nxt  = r_rdata;
                    w_tx_valid_nxt = 1'b1;
                    w_addr_nxt     = r_addr + ADDR_W'(1);
                    w_state_nxt    = S_RD_DUMMY;
                end
            end

            S_RD_DUMMY: begin
                if (w_stop) begin
                    w_rx_read_nxt = w_rx_take;
                    w_state_nxt   = S_IDLE;
                    w_active_nxt  = 1'b0;
                end else if (w_rx_take) begin
                    w_rx_read_nxt = 1'b1;
                    w_re_nxt      = 1'b1;
                    w_to_cnt_nxt  = '0;
                    w_state_nxt   = S_RD_REQ;
                end
            end

            default: begin
                w_state_nxt  = S_IDLE;
                w_we_nxt     = 1'b0;
                w_re_nxt     = 1'b0;
                w_active_nxt = 1'b0;
                w_abort_nxt  = 1'b0;
            end
        endcase
    end

    // Error flag and saturating counter; a new error beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else if (bus.err_clr) begin
            r_err_sticky <= w_err;
            r_err_count  <= w_err ? 8'd1 : 8'd0;
        end else if (w_err) begin
            r_err_sticky <= 1'b1;
            if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign bus.slv_rx_read  = r_rx_read;
    assign bus.slv_tx_data  = r_tx_data;
    assign bus.slv_tx_valid = r_tx_valid;
    assign bus.reg_addr     = r_addr;
    assign bus.reg_wdata    = r_wdata;
    assign bus.reg_we       = r_we;
    assign bus.reg_re       = r_re;
    assign bus.frame_active = r_active;
    assign bus.err_sticky   = r_err_sticky;
    assign bus.err_count    = r_err_count;
    assign bus.dbg_state    = r_state;

endmodule
